kick_charger: RTL and testbench

- Boost-capacitor charge controller that sits directly downstream of the kicker pulse stage.
- Consumes that stage's discharge drive (Dout) as kick_active and drives the boost converter MOSFET gate with fixed-frequency PWM until the capacitor comparator reports full.
- Publishes ready, which firmware and the shoot-arming logic use to permit the next kick.
- Inhibits charging during a kick and for a settle window after it.

---
 rtl/kick_charger.sv | 237 +++++++++++++++++++++++
 tb/tb_kick_charger.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kick_charger.sv
// kick_charger: boost-capacitor charge controller behind the kicker pulse stage.
// Latency: cap_full is seen 2 + FULL_FILTER cycles after it changes, and the state follows one edge later.
//          ready, charging and fault are registered from the next state. The gate is masked by kick_active with no delay.
// Backpressure: none. kick_active and enable=0 override charging at once, and FAULT holds until enable drops.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   reset        asynchronous active-low reset
//   enable       charging permitted (firmware register bit)
//   kick_active  kicker discharge in progress (Dout of the pulse stage)
//   cap_full     capacitor comparator, asynchronous to clk
//   gate         boost MOSFET gate drive
//   ready        capacitor charged, kick permitted
//   charging     high while in CHARGE
//   fault        charge timeout latched
//   state        current state encoding (IDLE=0 CHARGE=1 FULL=2 SETTLE=3 FAULT=4)
//
// Build option: define KICK_CHARGER_SOFTSTART_EN to ramp the PWM on-time from PWM_ON/4
// up to PWM_ON, one cycle per period, after each fresh charge. A top-up from FULL
// always starts at full on-time.
module kick_charger #(
    parameter int unsigned PWM_PERIOD     = 500,
    parameter int unsigned PWM_ON         = 350,
    parameter int unsigned SETTLE_CYCLES  = 5000,
    parameter int unsigned FULL_FILTER    = 16,
    parameter int unsigned CHARGE_TIMEOUT = 150000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       kick_active,
    input  logic       cap_full,
    output logic       gate,
    output logic       ready,
    output logic       charging,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHARGE = 3'd1;
    localparam logic [2:0] S_FULL   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [31:0] PERIOD32  = 32'(PWM_PERIOD);
    localparam logic [31:0] ON32      = 32'(PWM_ON);
    localparam logic [31:0] SETTLE32  = 32'(SETTLE_CYCLES);
    localparam logic [31:0] FILTER32  = 32'(FULL_FILTER);
    localparam logic [31:0] TIMEOUT32 = 32'(CHARGE_TIMEOUT);

    // ------------------------------------------------------------------
    // cap_full conditioning: 2-FF synchronizer, then a consecutive-sample filter
    // ------------------------------------------------------------------
    logic        sync1_q, sync2_q;
    logic        full_f_q, full_f_d;
    logic [31:0] filt_cnt_q, filt_cnt_d;

    always_comb begin
        full_f_d   = full_f_q;
        filt_cnt_d = 32'd0;
        if (sync2_q != full_f_q) begin
            // Accept the new level on the FULL_FILTER-th consecutive differing sample.
            if (filt_cnt_q + 32'd1 >= FILTER32) begin
                full_f_d   = sync2_q;
                filt_cnt_d = 32'd0;
            end else begin
                filt_cnt_d = filt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            full_f_q   <= 1'b0;
            filt_cnt_q <= 32'd0;
        end else begin
            sync1_q    <= cap_full;
            sync2_q    <= sync1_q;
            full_f_q   <= full_f_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [31:0] pwm_cnt_q, pwm_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [31:0] settle_cnt_q, settle_cnt_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = kick_active ? S_SETTLE : S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (kick_active) begin
                    state_d = S_SETTLE;
                end else if (full_f_q) begin
                    state_d = S_FULL;
                end else if (to_cnt_q + 32'd1 >= TIMEOUT32) begin
                    // This is the CHARGE_TIMEOUT-th consecutive cycle spent charging.
                    state_d = S_FAULT;
                end
            end
            S_FULL: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (kick_active) begin
                    state_d = S_SETTLE;
                end else if (!full_f_q) begin
                    state_d = S_CHARGE;
                end
            end
            S_SETTLE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!kick_active && (settle_cnt_q + 32'd1 >= SETTLE32)) begin
                    state_d = S_CHARGE;
                end
            end
            S_FAULT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic charge_entry;
    logic stay_charge;
    logic pwm_wrap;

    assign charge_entry = (state_d == S_CHARGE) && (state_q != S_CHARGE);
    assign stay_charge  = (state_d == S_CHARGE) && (state_q == S_CHARGE);
    assign pwm_wrap     = stay_charge && (pwm_cnt_q >= PERIOD32 - 32'd1);

    always_comb begin
        pwm_cnt_d = 32'd0;
        if (stay_charge && !pwm_wrap) begin
            pwm_cnt_d = pwm_cnt_q + 32'd1;
        end
    end

    // Timeout counts cycles in the current CHARGE stint and restarts on every entry.
    assign to_cnt_d = stay_charge ? to_cnt_q + 32'd1 : 32'd0;

    // Settle counts quiet cycles only. Any kick_active cycle restarts the window.
    always_comb begin
        settle_cnt_d = 32'd0;
        if ((state_d == S_SETTLE) && (state_q == S_SETTLE) && !kick_active) begin
            settle_cnt_d = settle_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // PWM on-time
    // ------------------------------------------------------------------
    logic [31:0] on_time;

`ifdef KICK_CHARGER_SOFTSTART_EN
    localparam logic [31:0] ON_START32 = 32'(PWM_ON / 4);

    logic [31:0] on_q, on_d;

    always_comb begin
        on_d = on_q;
        if (charge_entry) begin
            // A top-up from FULL needs no inrush limiting. The capacitor is nearly charged.
            on_d = (state_q == S_FULL) ? ON32 : ON_START32;
        end else if (pwm_wrap && (on_q < ON32)) begin
            on_d = on_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            on_q <= 32'd0;
        end else begin
            on_q <= on_d;
        end
    end

    assign on_time = on_d;
`else
    assign on_time = ON32;
`endif

    // ------------------------------------------------------------------
    // Registered outputs. Each one comes from the next state so that it lines up with state.
    // ------------------------------------------------------------------
    logic gate_q, gate_d;
    logic ready_q, charging_q, fault_q;

    assign gate_d = (state_d == S_CHARGE) && (pwm_cnt_d < on_time);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pwm_cnt_q    <= 32'd0;
            to_cnt_q     <= 32'd0;
            settle_cnt_q <= 32'd0;
            gate_q       <= 1'b0;
            ready_q      <= 1'b0;
            charging_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_cnt_q    <= pwm_cnt_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            gate_q       <= gate_d;
            ready_q      <= (state_d == S_FULL);
            charging_q   <= (state_d == S_CHARGE);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    // kick_active masks the gate combinationally. The registered gate may lag a kick
    // by one edge, and the MOSFET must never conduct while the kicker discharges.
    assign gate     = gate_q & ~kick_active;
    assign ready    = ready_q;
    assign charging = charging_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_kick_charger.sv
// tb_kick_charger: randomized bench for kick_charger against a cycle-level reference model.
// Latency: one model step per clock edge. Outputs are checked 1 ns after each edge and 1 ns after each input change.
// Backpressure: none; stimulus is free-running.
module tb_kick_charger;

    localparam int P   = 10;
    localparam int ON  = 7;
    localparam int ST  = 20;
    localparam int FF  = 4;
    localparam int TO  = 1000;

    localparam int M_IDLE   = 0;
    localparam int M_CHARGE = 1;
    localparam int M_FULL   = 2;
    localparam int M_SETTLE = 3;
    localparam int M_FAULT  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       kick_active;
    logic       cap_full;
    logic       gate;
    logic       ready;
    logic       charging;
    logic       fault;
    logic [2:0] state;

    always #5 clk = ~clk;

    kick_charger #(
        .PWM_PERIOD     (P),
        .PWM_ON         (ON),
        .SETTLE_CYCLES  (ST),
        .FULL_FILTER    (FF),
        .CHARGE_TIMEOUT (TO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .kick_active (kick_active),
        .cap_full    (cap_full),
        .gate        (gate),
        .ready       (ready),
        .charging    (charging),
        .fault       (fault),
        .state       (state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. It tracks the operating mode, how long the current charge
    // stint has run, how many quiet cycles have passed in settle, and the raw
    // cap_full samples taken at each edge.
    // ------------------------------------------------------------------
    int m_mode;
    int m_c;        // cycles elapsed in current charge stint
    int m_q;        // quiet cycles elapsed in settle
    bit m_topup;    // current stint entered from FULL
    bit m_full;     // filtered capacitor level
    bit hist [FF+1];  // hist[0] = cap_full at previous edge, hist[k] = k edges earlier

    function automatic int m_on_time();
`ifdef KICK_CHARGER_SOFTSTART_EN
        int on;
        if (m_topup) return ON;
        on = ON / 4 + m_c / P;
        return (on > ON) ? ON : on;
`else
        return ON;
`endif
    endfunction

    function automatic bit m_gate_reg();
        if (m_mode != M_CHARGE) return 1'b0;
        return (m_c % P) < m_on_time();
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_c     = 0;
        m_q     = 0;
        m_topup = 1'b0;
        m_full  = 1'b0;
        for (int k = 0; k <= FF; k++) hist[k] = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit kick, input bit cap);
        bit flip;
        // The synchronized level seen at this edge is the raw sample from two edges back.
        // The filter flips once FF such samples in a row disagree with the level it holds.
        flip = 1'b1;
        for (int k = 1; k <= FF; k++) if (hist[k] == m_full) flip = 1'b0;

        case (m_mode)
            M_IDLE: begin
                if (en && !kick) begin m_mode = M_CHARGE; m_c = 0; m_topup = 1'b0; end
                else if (en && kick) begin m_mode = M_SETTLE; m_q = 0; end
            end
            M_CHARGE: begin
                if (!en) m_mode = M_IDLE;
                else if (kick) begin m_mode = M_SETTLE; m_q = 0; end
                else if (m_full) m_mode = M_FULL;
                else if (m_c == TO - 1) m_mode = M_FAULT;
                else m_c++;
            end
            M_FULL: begin
                if (!en) m_mode = M_IDLE;
                else if (kick) begin m_mode = M_SETTLE; m_q = 0; end
                else if (!m_full) begin m_mode = M_CHARGE; m_c = 0; m_topup = 1'b1; end
            end
            M_SETTLE: begin
                if (!en) m_mode = M_IDLE;
                else if (kick) m_q = 0;
                else if (m_q == ST - 1) begin m_mode = M_CHARGE; m_c = 0; m_topup = 1'b0; end
                else m_q++;
            end
            default: begin
                if (!en) m_mode = M_IDLE;
            end
        endcase

        if (flip) m_full = !m_full;
        for (int k = FF; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = cap;
    endtask

    task automatic check_outputs(input string pfx);
        check_val({pfx, "_state"},    32'(state),    32'(m_mode));
        check_val({pfx, "_ready"},    32'(ready),    32'(m_mode == M_FULL));
        check_val({pfx, "_charging"}, 32'(charging), 32'(m_mode == M_CHARGE));
        check_val({pfx, "_fault"},    32'(fault),    32'(m_mode == M_FAULT));
        check_val({pfx, "_gate"},     32'(gate),     32'(m_gate_reg() & ~kick_active));
    endtask

    // Called at a negedge with new inputs already applied.
    task automatic tick();
        #1;
        check_val("gate_comb", 32'(gate), 32'(m_gate_reg() & ~kick_active));
        @(posedge clk);
        model_step(enable, kick_active, cap_full);
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Reset asserted in the middle of a cycle. The outputs must drop before any clock edge.
    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        kick_active = 1'b0;
        cap_full    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        reset = 1'b1;

        // Charge with PWM, then reach FULL.
        enable = 1'b1;
        run(25);
        cap_full = 1'b1;
        run(12);
        // Kick from FULL, drop cap_full, then settle and recharge.
        kick_active = 1'b1;
        cap_full    = 1'b0;
        run(40);
        kick_active = 1'b0;
        run(25);
        // A 3-cycle cap_full glitch is rejected.
        cap_full = 1'b1;
        run(3);
        cap_full = 1'b0;
        run(10);
        // Charge timeout, then clear the fault and restart.
        run(1010);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(3);
        // Kick while the gate is high.
        kick_active = 1'b1;
        run(1);
        kick_active = 1'b0;
        run(24);
        run(3);
        reset_pulse();
        run(5);
        // Top-up from FULL.
        cap_full = 1'b1;
        run(10);
        cap_full = 1'b0;
        run(8);
        cap_full = 1'b1;
        run(15);

        for (int seg = 0; seg < 90; seg++) begin
            case ($urandom_range(0, 7))
                0: begin
                    enable = 1'b1; kick_active = 1'b0; cap_full = 1'b0;
                    run($urandom_range(5, 40));
                end
                1: begin
                    cap_full = 1'b1;
                    run($urandom_range(3, 30));
                end
                2: begin
                    cap_full = ~cap_full;
                    run($urandom_range(1, 3));
                    cap_full = ~cap_full;
                    run(8);
                end
                3: begin
                    kick_active = 1'b1;
                    if ($urandom_range(0, 1) == 1) cap_full = 1'b0;
                    run($urandom_range(1, 50));
                    kick_active = 1'b0;
                    run($urandom_range(10, 30));
                end
                4: begin
                    enable = 1'b0;
                    run($urandom_range(1, 5));
                    enable = 1'b1;
                    run(3);
                end
                5: begin
                    cap_full = 1'b0;
                    run($urandom_range(6, 15));
                    cap_full = 1'b1;
                    run($urandom_range(10, 25));
                end
                6: begin
                    if ($urandom_range(0, 3) == 0) begin
                        enable = 1'b1; kick_active = 1'b0; cap_full = 1'b0;
                        run(TO + 10);
                        enable = 1'b0;
                        run(2);
                        enable = 1'b1;
                    end
                    run(5);
                end
                default: begin
                    run($urandom_range(0, 9));
                    reset_pulse();
                    run(4);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
